// File: rtl/io_port_unit_pkg.sv
// Shared constants for the processor I/O port unit: default data width, FIFO depths
// and the pointer-width helper used by the FIFO instances.
package io_port_unit_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_IN_DEPTH  = 4;
    localparam int DEFAULT_OUT_DEPTH = 4;

    // Pointer width for a power-of-two FIFO depth; the count needs one extra bit.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/io_port_unit_fifo.sv
// Show-ahead synchronous FIFO used on both sides of the I/O port unit.
// Full/empty come from the registered count only, so flags never depend on same-cycle requests.
module io_port_unit_fifo
    import io_port_unit_pkg::*;
#(
    parameter int W     = DEFAULT_DATA_W,
    parameter int DEPTH = DEFAULT_IN_DEPTH
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = ptrWidth(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULLCOUNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          pushEn;
    logic          popEn;

    assign full   = (count == FULLCOUNT);
    assign empty  = (count == '0);
    assign pushEn = push & ~full;
    assign popEn  = pop & ~empty;
    assign head   = empty ? '0 : mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pushEn) begin
                mem[wrPtr] <= wdata;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// Processor I/O port buffering: external producer -> input FIFO -> IN, and
// writeback OUT -> output FIFO -> external consumer, with stall flags for the hazard unit.
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int IN_DEPTH  = DEFAULT_IN_DEPTH,
    parameter int OUT_DEPTH = DEFAULT_OUT_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    input  logic              in_req,
    output logic [DATA_W-1:0] in_data,
    output logic              in_stall,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_wdata,
    output logic              out_stall,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic              ovf_sticky
);

    logic inFull;
    logic inEmpty;
    logic outFull;
    logic outEmpty;

    io_port_unit_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) inFifo (
        .clk   (clk),
        .reset_n(reset_n),
        .push  (ext_in_valid),
        .wdata (ext_in_data),
        .pop   (in_req),
        .head  (in_data),
        .full  (inFull),
        .empty (inEmpty)
    );

    io_port_unit_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) outFifo (
        .clk   (clk),
        .reset_n(reset_n),
        .push  (out_req),
        .wdata (out_wdata),
        .pop   (ext_out_ready),
        .head  (ext_out_data),
        .full  (outFull),
        .empty (outEmpty)
    );

    assign ext_in_ready  = ~inFull;
    assign in_stall      = inEmpty;
    assign out_stall     = outFull;
    assign ext_out_valid = ~outEmpty;

    // An OUT that arrives while the output FIFO is full is lost; remember it until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_req && outFull) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: queue-based model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_io_port_unit;

    localparam int DATA_W    = 16;
    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [DATA_W-1:0] ext_in_data = '0;
    logic              ext_in_valid = 1'b0;
    logic              ext_in_ready;
    logic              in_req = 1'b0;
    logic [DATA_W-1:0] in_data;
    logic              in_stall;
    logic              out_req = 1'b0;
    logic [DATA_W-1:0] out_wdata = '0;
    logic              out_stall;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready = 1'b0;
    logic              ovf_sticky;

    int checkCount = 0;
    int failCount  = 0;

    logic [DATA_W-1:0] inQ[$];
    logic [DATA_W-1:0] outQ[$];
    logic              modelOvf = 1'b0;

    io_port_unit #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .in_req       (in_req),
        .in_data      (in_data),
        .in_stall     (in_stall),
        .out_req      (out_req),
        .out_wdata    (out_wdata),
        .out_stall    (out_stall),
        .ext_out_data (ext_out_data),
        .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready),
        .ovf_sticky   (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic vIn, input logic [DATA_W-1:0] dIn, input logic rIn,
                                 input logic rOut, input logic [DATA_W-1:0] dOut, input logic rdyOut);
        ext_in_valid  = vIn;
        ext_in_data   = dIn;
        in_req        = rIn;
        out_req       = rOut;
        out_wdata     = dOut;
        ext_out_ready = rdyOut;
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: plain queues, each side updated once per rising edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inQ.delete();
            outQ.delete();
            modelOvf = 1'b0;
        end else begin
            automatic bit inAccept  = ext_in_valid && (inQ.size() < IN_DEPTH);
            automatic bit inTake    = in_req && (inQ.size() > 0);
            automatic bit outAccept = out_req && (outQ.size() < OUT_DEPTH);
            automatic bit outTake   = ext_out_ready && (outQ.size() > 0);
            if (out_req && !outAccept) modelOvf = 1'b1;
            if (inTake) void'(inQ.pop_front());
            if (inAccept) inQ.push_back(ext_in_data);
            if (outTake) void'(outQ.pop_front());
            if (outAccept) outQ.push_back(out_wdata);
        end
    end

    always @(negedge clk) begin
        checkFlag("ext_in_ready", ext_in_ready, inQ.size() < IN_DEPTH);
        checkFlag("in_stall", in_stall, inQ.size() == 0);
        checkOutput("in_data", in_data, (inQ.size() > 0) ? inQ[0] : '0);
        checkFlag("out_stall", out_stall, outQ.size() == OUT_DEPTH);
        checkFlag("ext_out_valid", ext_out_valid, outQ.size() > 0);
        checkOutput("ext_out_data", ext_out_data, (outQ.size() > 0) ? outQ[0] : '0);
        checkFlag("ovf_sticky", ovf_sticky, modelOvf);
    end

    initial begin
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        applyStimulus(0, '0, 0, 0, '0, 0);

        // Reset in the middle of traffic with three words buffered on each side.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 16'h1100 + 16'(i), 0, 1, 16'h2200 + 16'(i), 0);
        end
        applyStimulus(0, '0, 0, 0, '0, 0);
        reset_n = 1'b0;
        #2;
        checkFlag("rst_in_ready", ext_in_ready, 1'b1);
        checkFlag("rst_in_stall", in_stall, 1'b1);
        checkOutput("rst_in_data", in_data, 16'h0000);
        checkFlag("rst_out_valid", ext_out_valid, 1'b0);
        checkOutput("rst_out_data", ext_out_data, 16'h0000);
        applyStimulus(0, '0, 0, 0, '0, 0);
        reset_n = 1'b1;
        applyStimulus(0, '0, 0, 0, '0, 0);
        checkFlag("post_rst_stall", in_stall, 1'b1);

        // In-order delivery to the processor.
        applyStimulus(1, 16'hA001, 0, 0, '0, 0);
        checkOutput("in_first", in_data, 16'hA001);
        applyStimulus(1, 16'hA002, 0, 0, '0, 0);
        applyStimulus(1, 16'hA003, 0, 0, '0, 0);
        applyStimulus(0, '0, 1, 0, '0, 0);
        checkOutput("in_pop1", in_data, 16'hA002);
        applyStimulus(0, '0, 1, 0, '0, 0);
        checkOutput("in_pop2", in_data, 16'hA003);
        applyStimulus(0, '0, 1, 0, '0, 0);
        checkOutput("in_pop3", in_data, 16'h0000);
        checkFlag("in_empty_stall", in_stall, 1'b1);
        applyStimulus(0, '0, 1, 0, '0, 0);
        checkOutput("in_req_empty", in_data, 16'h0000);

        // Fill the input FIFO, overrun it, then push+pop while full.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 16'hC000 + 16'(i), 0, 0, '0, 0);
            if (i == 3) checkFlag("in_full_after4", ext_in_ready, 1'b0);
        end
        checkOutput("in_full_head", in_data, 16'hC000);
        applyStimulus(1, 16'hC0FF, 1, 0, '0, 0);
        checkFlag("in_full_pp_ready", ext_in_ready, 1'b1);
        checkOutput("in_full_pp_head", in_data, 16'hC001);
        applyStimulus(0, '0, 1, 0, '0, 0);
        applyStimulus(0, '0, 1, 0, '0, 0);
        checkOutput("in_last_of_three", in_data, 16'hC003);
        applyStimulus(0, '0, 1, 0, '0, 0);
        checkFlag("in_drained", in_stall, 1'b1);

        // Push and pop together on an empty input FIFO.
        applyStimulus(1, 16'h0055, 1, 0, '0, 0);
        checkOutput("empty_pp_data", in_data, 16'h0055);
        checkFlag("empty_pp_stall", in_stall, 1'b0);
        applyStimulus(0, '0, 1, 0, '0, 0);

        // Output overflow with the consumer stalled, then drain.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, '0, 0, 1, 16'hB000 + 16'(i), 0);
            if (i == 3) checkFlag("out_stall_after4", out_stall, 1'b1);
        end
        checkFlag("ovf_set", ovf_sticky, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("out_drain", ext_out_data, 16'hB000 + 16'(i));
            applyStimulus(0, '0, 0, 0, '0, 1);
        end
        checkFlag("out_drained_valid", ext_out_valid, 1'b0);
        checkFlag("ovf_holds", ovf_sticky, 1'b1);

        // Random traffic on both sides to exercise pointer wrap.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, '0, 1, 0, '0, 1);
        end
        checkFlag("final_in_empty", in_stall, 1'b1);
        checkFlag("final_out_empty", ext_out_valid, 1'b0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
